// File: rtl/serial_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } result_t;

  localparam result_t RES_CLR = '0;

endpackage

// File: rtl/serial_comparator_digit_compare.sv
// Combinational magnitude compare of one DIGIT-wide slice.
// Zero latency; no flow control.
module digit_compare #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  output logic             gt,
  output logic             lt
);

  assign gt = (x > y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial a-vs-b compare, MSB slice first with early exit on the first difference.
// Latency 1..WIDTH/DIGIT cycles from capture; start is ignored while busy.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt;
  result_t          res;
  logic             dgt;
  logic             dlt;
  logic [WIDTH-1:0] flip;

  // Biasing the sign bit maps two's-complement order onto unsigned order.
  assign flip = signed_mode ? MSB : '0;

  // Operands shift left each RUN cycle so the slice under test is always the top one.
  digit_compare #(.DIGIT(DIGIT)) u_digit (
    .x  (a_q[WIDTH-1 -: DIGIT]),
    .y  (b_q[WIDTH-1 -: DIGIT]),
    .gt (dgt),
    .lt (dlt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      res   <= RES_CLR;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (dgt || dlt) begin
            res.gt <= dgt;
            res.eq <= 1'b0;
            res.lt <= dlt;
            cnt    <= '0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (cnt == CW'(1)) begin
            res.gt <= 1'b0;
            res.eq <= 1'b1;
            res.lt <= 1'b0;
            cnt    <= '0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
            a_q <= a_q << DIGIT;
            b_q <= b_q << DIGIT;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a ^ flip;
            b_q   <= b ^ flip;
            cnt   <= CW'(NDIG);
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign gt = res.gt;
  assign eq = res.eq;
  assign lt = res.lt;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator: four configurations share one driver, one reference model and one checker.
module tb_serial_comparator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_drv = 1'b0;
  logic [7:0] a_drv = '0;
  logic [7:0] b_drv = '0;
  logic       sm_drv = 1'b0;
  logic [1:0] sel = 2'd0;

  logic busy_v [4];
  logic done_v [4];
  logic gt_v   [4];
  logic eq_v   [4];
  logic lt_v   [4];

  always #5 clk = ~clk;

  serial_comparator #(.WIDTH(8), .DIGIT(2)) u_w8d2 (
    .clk(clk), .rst(rst), .start(start_drv && sel == 2'd0), .a(a_drv), .b(b_drv),
    .signed_mode(sm_drv), .busy(busy_v[0]), .done(done_v[0]), .gt(gt_v[0]), .eq(eq_v[0]), .lt(lt_v[0]));
  serial_comparator #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(start_drv && sel == 2'd1), .a(a_drv), .b(b_drv),
    .signed_mode(sm_drv), .busy(busy_v[1]), .done(done_v[1]), .gt(gt_v[1]), .eq(eq_v[1]), .lt(lt_v[1]));
  serial_comparator #(.WIDTH(4), .DIGIT(1)) u_w4d1 (
    .clk(clk), .rst(rst), .start(start_drv && sel == 2'd2), .a(a_drv[3:0]), .b(b_drv[3:0]),
    .signed_mode(sm_drv), .busy(busy_v[2]), .done(done_v[2]), .gt(gt_v[2]), .eq(eq_v[2]), .lt(lt_v[2]));
  serial_comparator #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst(rst), .start(start_drv && sel == 2'd3), .a(a_drv[3:0]), .b(b_drv[3:0]),
    .signed_mode(sm_drv), .busy(busy_v[3]), .done(done_v[3]), .gt(gt_v[3]), .eq(eq_v[3]), .lt(lt_v[3]));

  logic busy_o, done_o, gt_o, eq_o, lt_o;
  assign busy_o = busy_v[sel];
  assign done_o = done_v[sel];
  assign gt_o   = gt_v[sel];
  assign eq_o   = eq_v[sel];
  assign lt_o   = lt_v[sel];

  function automatic int w_of(input logic [1:0] s);
    return (s < 2) ? 8 : 4;
  endfunction

  function automatic int d_of(input logic [1:0] s);
    return (s == 0 || s == 3) ? 2 : 1;
  endfunction

  // Golden result {gt,eq,lt} from integer values of the operands.
  function automatic logic [2:0] res_of(input logic [7:0] a, input logic [7:0] b, input logic sm, input int w);
    int sa, sb;
    sa = int'(a) & ((1 << w) - 1);
    sb = int'(b) & ((1 << w) - 1);
    if (sm) begin
      if (sa >= (1 << (w - 1))) sa = sa - (1 << w);
      if (sb >= (1 << (w - 1))) sb = sb - (1 << w);
    end
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  // Golden latency: 1-based index of the first differing slice from the MSB, else slice count.
  function automatic int lat_of(input logic [7:0] a, input logic [7:0] b, input int w, input int d);
    int x, nd;
    x  = int'(a ^ b) & ((1 << w) - 1);
    nd = w / d;
    for (int i = 1; i <= nd; i++)
      if (((x >> (w - i * d)) & ((1 << d) - 1)) != 0) return i;
    return nd;
  endfunction

  // Reference model: a pending result matures a fixed number of cycles after capture.
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [2:0] m_res  = 3'b000;
  logic [2:0] m_pend = 3'b000;
  int         m_rem  = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
      m_pend <= 3'b000;
      m_rem  <= 0;
    end else if (!m_busy && start_drv) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_rem  <= lat_of(a_drv, b_drv, w_of(sel), d_of(sel));
      m_pend <= res_of(a_drv, b_drv, sm_drv, w_of(sel));
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_rem <= m_rem - 1;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Directed expectations queued by the stimulus and settled by the checker.
  string lit_nm  [$];
  int    lit_got [$];
  int    lit_exp [$];

  task automatic push(input string nm, input int got, input int exp);
    lit_nm.push_back(nm);
    lit_got.push_back(got);
    lit_exp.push_back(exp);
  endtask

  bit chk_en = 1'b0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int rd_idx = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if ({busy_o, done_o, gt_o, eq_o, lt_o} !== {m_busy, m_done, m_res}) begin
        n_bad++;
        $display("FAIL cycle t=%0t sel=%0d busy,done,gt,eq,lt got=%b exp=%b",
                 $time, sel, {busy_o, done_o, gt_o, eq_o, lt_o}, {m_busy, m_done, m_res});
      end
    end
    while (rd_idx < lit_got.size()) begin
      n_cmp++;
      if (lit_got[rd_idx] != lit_exp[rd_idx]) begin
        n_bad++;
        $display("FAIL %s got=%0d exp=%0d", lit_nm[rd_idx], lit_got[rd_idx], lit_exp[rd_idx]);
      end
      rd_idx++;
    end
  end

  task automatic wait_done(output logic [2:0] res, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!done_o && lat < 40);
    if (!done_o) lat = -1;
    res = {gt_o, eq_o, lt_o};
  endtask

  task automatic do_cmp(input logic [7:0] a, input logic [7:0] b, input logic sm,
                        output logic [2:0] res, output int lat);
    @(posedge clk); #1;
    a_drv = a; b_drv = b; sm_drv = sm; start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    a_drv = ~a; b_drv = a; sm_drv = ~sm;
    wait_done(res, lat);
  endtask

  task automatic switch_to(input logic [1:0] s);
    @(posedge clk); #1;
    rst = 1'b1;
    sel = s;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  logic [2:0] res;
  int         lat;
  int         nb;
  int         cnt;
  int         ntests;
  logic [7:0] pa [3];
  logic [7:0] pb [3];
  logic [2:0] pr [3];
  int         pl [3];

  initial begin
    pa = '{8'h80, 8'hA5, 8'h12};
    pb = '{8'h7F, 8'hA5, 8'h13};
    pr = '{3'b100, 3'b010, 3'b001};
    pl = '{1, 4, 4};

    push("pin-unsigned", int'(res_of(8'h80, 8'h7F, 1'b0, 8)), 3'b100);
    push("pin-signed", int'(res_of(8'h80, 8'h7F, 1'b1, 8)), 3'b001);
    push("pin-signed4", int'(res_of(8'h08, 8'h07, 1'b1, 4)), 3'b001);
    push("pin-lat", lat_of(8'h12, 8'h13, 8, 2), 4);

    @(posedge clk); @(posedge clk); #1;
    chk_en = 1'b1;
    push("reset-outputs", int'({busy_o, done_o, gt_o, eq_o, lt_o}), 0);
    rst = 1'b0;

    do_cmp(8'h80, 8'h7F, 1'b0, res, lat);
    push("u80v7f-res", int'(res), 3'b100); push("u80v7f-lat", lat, 1);
    do_cmp(8'h80, 8'h7F, 1'b1, res, lat);
    push("s80v7f-res", int'(res), 3'b001); push("s80v7f-lat", lat, 1);
    do_cmp(8'hA5, 8'hA5, 1'b0, res, lat);
    push("a5eq-res", int'(res), 3'b010); push("a5eq-lat", lat, 4);
    do_cmp(8'h12, 8'h13, 1'b0, res, lat);
    push("12v13-res", int'(res), 3'b001); push("12v13-lat", lat, 4);

    // Second start one cycle into RUN must be ignored.
    @(posedge clk); #1;
    a_drv = 8'h03; b_drv = 8'h02; sm_drv = 1'b0; start_drv = 1'b1;
    @(posedge clk); #1;
    a_drv = 8'h00; b_drv = 8'hFF;
    nb = busy_o ? 1 : 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start_drv = 1'b0;
      if (busy_o) nb++;
    end while (!done_o && lat < 40);
    push("ignore-res", int'({gt_o, eq_o, lt_o}), 3'b100);
    push("ignore-lat", done_o ? lat : -1, 4);
    push("ignore-busy", nb, 4);

    // start held high: each DONE cycle recaptures immediately.
    @(posedge clk); #1;
    a_drv = pa[0]; b_drv = pb[0]; sm_drv = 1'b0; start_drv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      push("b2b-busy", int'(busy_o), 1);
      if (i < 2) begin
        a_drv = pa[i+1]; b_drv = pb[i+1];
      end else begin
        start_drv = 1'b0;
      end
      wait_done(res, lat);
      push("b2b-res", int'(res), int'(pr[i]));
      push("b2b-lat", lat, pl[i]);
    end

    // Abort mid-RUN via asynchronous reset.
    switch_to(2'd1);
    do_cmp(8'h05, 8'h05, 1'b0, res, lat);
    push("w8d1-eq-res", int'(res), 3'b010); push("w8d1-eq-lat", lat, 8);
    @(posedge clk); #1;
    a_drv = 8'h01; b_drv = 8'h00; sm_drv = 1'b0; start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1;
    push("rst-immediate", int'({busy_o, done_o, gt_o, eq_o, lt_o}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) cnt++;
    end
    push("rst-no-done", cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a_drv = 8'h01; b_drv = 8'h00; sm_drv = 1'b0; start_drv = 1'b1;
    @(posedge clk); #1;
    start_drv = 1'b0;
    wait_done(res, lat);
    push("post-rst-res", int'(res), 3'b100); push("post-rst-lat", lat, 8);

    // Exhaustive 4-bit sweep in both digit sizes and both modes.
    ntests = 0;
    for (int s = 2; s < 4; s++) begin
      switch_to(2'(s));
      for (int m = 0; m < 2; m++)
        for (int x = 0; x < 16; x++)
          for (int y = 0; y < 16; y++) begin
            do_cmp(8'(x), 8'(y), m[0], res, lat);
            push("exh-res", int'(res), int'(res_of(8'(x), 8'(y), m[0], 4)));
            push("exh-lat", lat, lat_of(8'(x), 8'(y), 4, d_of(2'(s))));
            ntests++;
          end
    end
    $display("exhaustive 4-bit sweep: %0d comparisons run", ntests);

    repeat (3) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
